vxe_cu_cmd_encoder: RTL and testbench
=====================================

VXE_CU_CMD_ENCODER -- requirements
Module: vxe_cu_cmd_encoder

Interface
REQ-001 SHALL have parameter NTHR, default 8, meaning number of VPU threads (1..8); thread Id is encoded in fun[2:0] and fun[7:3] is always 0.
REQ-002 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port nrst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port i_job_valid  input  1  job descriptor valid.
REQ-005 SHALL have port o_job_ready  output  1  encoder can accept a job.
REQ-006 SHALL have port i_job_nthr  input  3  index of last active thread (threads 0..nthr enabled).
REQ-007 SHALL have port i_job_acc  input  32  initial accumulator value, all threads.
REQ-008 SHALL have port i_job_vl  input  20  vector length, all threads.
REQ-009 SHALL have ports i_job_rs, i_job_rd  input  38 each  base word addresses of thread 0 source and destination.
REQ-010 SHALL have ports i_job_rs_stride, i_job_rd_stride  input  38 each  per-thread address increments.
REQ-011 SHALL have port i_job_rt  input  38  shared vector address, same for all threads.
REQ-012 SHALL have port i_job_act  input  2  activation: 0 none, 1 RELU, 2 LRELU, 3 reserved (treated as none).
REQ-013 SHALL have port i_job_lsh  input  7  leaky ReLU shift.
REQ-014 SHALL have port i_job_sync  input  2  SYNC payload bits.
REQ-015 SHALL have port o_cmd  output  64  command word {op[4:0], fun[7:0], pl}.
REQ-016 SHALL have port o_cmd_valid  output  1  o_cmd valid.
REQ-017 SHALL have port i_cmd_ready  input  1  consumer accepts o_cmd.
REQ-018 SHALL have port o_busy  output  1  job in progress (state != IDLE).

Function
REQ-019 Job SHALL be accepted when i_job_valid && o_job_ready; all descriptor fields latched; o_job_ready = 1 only in IDLE.
REQ-020 FSM states: IDLE, THR (per-thread setup), DIS (disable unused), PROD, ACT, STORE, SYNC; IDLE->THR on accept.
REQ-021 THR SHALL emit, per thread t = 0..nthr in order: SETACC {08,t,19'0,acc}; SETVL {09,t,31'0,vl}; SETRS {0C,t,13'0,rs_t}; SETRT {0D,t,13'0,rt}; SETRD {0E,t,13'0,rd_t}; SETEN {0A,t,50'0,1}.
REQ-022 rs_t = rs + t*rs_stride, rd_t = rd + t*rd_stride, modulo 2^38, produced by running adders updated after each thread's SETEN (no multiplier).
REQ-023 THR->DIS after thread nthr if nthr < NTHR-1, else ->PROD; DIS SHALL emit SETEN {0A,t,50'0,0} for t = nthr+1..NTHR-1.
REQ-024 PROD emits {01,59'0}; ->ACT if act = 1 or 2, else ->STORE.
REQ-025 ACT emits RELU {02,8'h00,51'0} for act=1, LRELU {02,8'h01,44'0,lsh} for act=2.
REQ-026 STORE emits {10,59'0}; SYNC emits {18,57'0,sync}; SYNC->IDLE on its handshake.
REQ-027 All reserved bits SHALL be 0; every emitted word SHALL decode without error.
REQ-028 First o_cmd_valid SHALL assert the cycle after job acceptance; one word per cycle while i_cmd_ready = 1.
REQ-029 While o_cmd_valid = 1 and i_cmd_ready = 0, o_cmd and o_cmd_valid SHALL hold stable; advance only on handshake.
REQ-030 o_cmd_valid SHALL not drop between words of one job unless handshake completes the last SYNC.
REQ-031 Total words per job = 6*(nthr+1) + (NTHR-1-nthr) + 3 + (act in {1,2}).
REQ-032 Descriptor input changes after acceptance SHALL not affect the running job.
REQ-033 Next job SHALL be accepted no earlier than the cycle after SYNC handshake (o_job_ready rises that cycle).

Reset
REQ-034 nrst = 0 at a clock edge SHALL force IDLE, o_cmd_valid = 0, o_busy = 0, o_job_ready = 1 (after release), o_cmd = 0, address registers 0.
REQ-035 Reset mid-job SHALL abandon the job; no further words emitted until a new job is accepted.

Verification
REQ-036 nthr=0, act=0, acc=FFFFFFFF, vl=100, ready=1 -> 16 words: 6 setup for thread 0, SETEN(0) threads 1..7, PROD, STORE, SYNC; valid contiguous 16 cycles.
REQ-037 nthr=7, act=2, lsh=4, rs=1000, rs_stride=40, rd=2000, rd_stride=8 -> 52 words; thread 7 SETRS pl=1118, SETRD pl=2038; LRELU word {02,01,44'0,7'h04}.
REQ-038 nthr=3, random i_cmd_ready stalls -> o_cmd stable across stalls; sequence identical to no-stall run; 31 words.
REQ-039 rs=3FFFFFFFF0, rs_stride=10, nthr=1 -> thread 1 SETRS pl=0000000000 (wrap).
REQ-040 nrst low during thread 2 setup -> next cycle o_cmd_valid=0, o_busy=0; new job restarts at SETACC thread 0.
REQ-041 Every emitted word fed to vxe_cu_cmd_decoder -> o_dec_err = 0; act=3 -> no ACT word.

Source files
------------

// File: rtl/vxe_cu_cmd_encoder.sv
// vxe_cu_cmd_encoder
// Expands one job descriptor into the command-word stream that programs the
// VPU threads, runs the product, applies the optional activation, stores the
// result and issues a SYNC.
//
// Ports:
//   clk, nrst            clock, synchronous active-low reset
//   i_job_valid          job descriptor valid
//   o_job_ready          encoder idle and able to take a job
//   i_job_nthr           index of last active thread
//   i_job_acc, i_job_vl  accumulator init value, vector length
//   i_job_rs, i_job_rd   thread 0 source / destination word addresses
//   i_job_rs_stride,
//   i_job_rd_stride      per-thread address increments
//   i_job_rt             shared vector address
//   i_job_act, i_job_lsh activation select, leaky ReLU shift
//   i_job_sync           SYNC payload
//   o_cmd, o_cmd_valid,
//   i_cmd_ready          command word stream {op[4:0], fun[7:0], pl[50:0]}
//   o_busy               a job is being emitted
module vxe_cu_cmd_encoder #(
  parameter int NTHR = 8
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        i_job_valid,
  output logic        o_job_ready,
  input  logic [2:0]  i_job_nthr,
  input  logic [31:0] i_job_acc,
  input  logic [19:0] i_job_vl,
  input  logic [37:0] i_job_rs,
  input  logic [37:0] i_job_rd,
  input  logic [37:0] i_job_rs_stride,
  input  logic [37:0] i_job_rd_stride,
  input  logic [37:0] i_job_rt,
  input  logic [1:0]  i_job_act,
  input  logic [6:0]  i_job_lsh,
  input  logic [1:0]  i_job_sync,
  output logic [63:0] o_cmd,
  output logic        o_cmd_valid,
  input  logic        i_cmd_ready,
  output logic        o_busy
);

  typedef enum logic [2:0] {IDLE, THR, DIS, PROD, ACT, STORE, SYNC} state_t;

  localparam logic [2:0] LAST_THR = 3'(NTHR - 1);

  state_t      state, state_nxt;
  logic [2:0]  nthr_q;
  logic [31:0] acc_q;
  logic [19:0] vl_q;
  logic [37:0] rs_cur, rd_cur;
  logic [37:0] rs_stride_q, rd_stride_q, rt_q;
  logic [1:0]  act_q;
  logic [6:0]  lsh_q;
  logic [1:0]  sync_q;
  logic [2:0]  thr_q;
  logic [2:0]  step_q;
  logic [7:0]  fun;
  logic        accept, fire, has_act;

  assign accept  = i_job_valid && o_job_ready;
  assign fire    = o_cmd_valid && i_cmd_ready;
  // Reserved activation code 3 behaves as "no activation".
  assign has_act = (act_q == 2'd1) || (act_q == 2'd2);

  always_ff @(posedge clk) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // The FSM only moves on a handshake, so a stalled word stays on o_cmd.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = THR;
      THR:   if (fire && step_q == 3'd5 && thr_q == nthr_q)
               state_nxt = (nthr_q < LAST_THR) ? DIS : PROD;
      DIS:   if (fire && thr_q == LAST_THR) state_nxt = PROD;
      PROD:  if (fire) state_nxt = has_act ? ACT : STORE;
      ACT:   if (fire) state_nxt = STORE;
      STORE: if (fire) state_nxt = SYNC;
      SYNC:  if (fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Descriptor capture and the per-thread sequencing counters. rs_cur/rd_cur
  // hold the current thread's addresses and step by the stride once that
  // thread's SETEN has been taken, so no multiplier is needed.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      nthr_q      <= '0;
      acc_q       <= '0;
      vl_q        <= '0;
      rs_cur      <= '0;
      rd_cur      <= '0;
      rs_stride_q <= '0;
      rd_stride_q <= '0;
      rt_q        <= '0;
      act_q       <= '0;
      lsh_q       <= '0;
      sync_q      <= '0;
      thr_q       <= '0;
      step_q      <= '0;
    end else if (accept) begin
      nthr_q      <= (i_job_nthr > LAST_THR) ? LAST_THR : i_job_nthr;
      acc_q       <= i_job_acc;
      vl_q        <= i_job_vl;
      rs_cur      <= i_job_rs;
      rd_cur      <= i_job_rd;
      rs_stride_q <= i_job_rs_stride;
      rd_stride_q <= i_job_rd_stride;
      rt_q        <= i_job_rt;
      act_q       <= i_job_act;
      lsh_q       <= i_job_lsh;
      sync_q      <= i_job_sync;
      thr_q       <= '0;
      step_q      <= '0;
    end else if (fire) begin
      case (state)
        THR: begin
          if (step_q == 3'd5) begin
            step_q <= '0;
            thr_q  <= thr_q + 3'd1;
            rs_cur <= rs_cur + rs_stride_q;
            rd_cur <= rd_cur + rd_stride_q;
          end else begin
            step_q <= step_q + 3'd1;
          end
        end
        DIS:     thr_q <= thr_q + 3'd1;
        default: ;
      endcase
    end
  end

  // Command word formation; IDLE drives an all-zero word.
  always_comb begin
    fun         = {5'b0, thr_q};
    o_cmd       = '0;
    o_cmd_valid = (state != IDLE);
    o_busy      = (state != IDLE);
    o_job_ready = (state == IDLE);
    case (state)
      THR: begin
        case (step_q)
          3'd0:    o_cmd = {5'h08, fun, 19'b0, acc_q};
          3'd1:    o_cmd = {5'h09, fun, 31'b0, vl_q};
          3'd2:    o_cmd = {5'h0C, fun, 13'b0, rs_cur};
          3'd3:    o_cmd = {5'h0D, fun, 13'b0, rt_q};
          3'd4:    o_cmd = {5'h0E, fun, 13'b0, rd_cur};
          default: o_cmd = {5'h0A, fun, 50'b0, 1'b1};
        endcase
      end
      DIS:   o_cmd = {5'h0A, fun, 51'b0};
      PROD:  o_cmd = {5'h01, 59'b0};
      ACT:   o_cmd = (act_q == 2'd2) ? {5'h02, 8'h01, 44'b0, lsh_q}
                                     : {5'h02, 8'h00, 51'b0};
      STORE: o_cmd = {5'h10, 59'b0};
      SYNC:  o_cmd = {5'h18, 57'b0, sync_q};
      default: o_cmd = '0;
    endcase
  end

endmodule

// File: tb/tb_vxe_cu_cmd_encoder.sv
// tb_vxe_cu_cmd_encoder
// Table-driven bench for vxe_cu_cmd_encoder: each record is a job descriptor
// with its expected word count and hand-computed probe words; the complete
// stream is also compared against a reference built from the descriptor.
// Hand-written sequences cover reset state and reset in the middle of a job.
module tb_vxe_cu_cmd_encoder;

  localparam int NTHR = 8;

  logic        clk = 1'b0;
  logic        nrst;
  logic        i_job_valid;
  logic        o_job_ready;
  logic [2:0]  i_job_nthr;
  logic [31:0] i_job_acc;
  logic [19:0] i_job_vl;
  logic [37:0] i_job_rs, i_job_rd, i_job_rs_stride, i_job_rd_stride, i_job_rt;
  logic [1:0]  i_job_act;
  logic [6:0]  i_job_lsh;
  logic [1:0]  i_job_sync;
  logic [63:0] o_cmd;
  logic        o_cmd_valid;
  logic        i_cmd_ready;
  logic        o_busy;

  vxe_cu_cmd_encoder #(.NTHR(NTHR)) dut (
    .clk(clk), .nrst(nrst),
    .i_job_valid(i_job_valid), .o_job_ready(o_job_ready),
    .i_job_nthr(i_job_nthr), .i_job_acc(i_job_acc), .i_job_vl(i_job_vl),
    .i_job_rs(i_job_rs), .i_job_rd(i_job_rd),
    .i_job_rs_stride(i_job_rs_stride), .i_job_rd_stride(i_job_rd_stride),
    .i_job_rt(i_job_rt), .i_job_act(i_job_act), .i_job_lsh(i_job_lsh),
    .i_job_sync(i_job_sync),
    .o_cmd(o_cmd), .o_cmd_valid(o_cmd_valid), .i_cmd_ready(i_cmd_ready),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  nthr;
    logic [31:0] acc;
    logic [19:0] vl;
    logic [37:0] rs, rd, rs_stride, rd_stride, rt;
    logic [1:0]  act;
    logic [6:0]  lsh;
    logic [1:0]  sync;
    bit          stall;
    int          exp_count;
    int          probe_idx0;
    logic [63:0] probe_word0;
    int          probe_idx1;
    logic [63:0] probe_word1;
  } vec_t;

  vec_t        vecs[6];
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, actual, expected);
    end
  endtask

  // Reference stream computed straight from the descriptor, using
  // multiplication for the per-thread addresses.
  task automatic buildExpected(input vec_t v);
    logic [37:0] rs_t, rd_t;
    logic [7:0]  f;
    exp_q.delete();
    for (int t = 0; t <= int'(v.nthr); t++) begin
      rs_t = v.rs + 38'(t) * v.rs_stride;
      rd_t = v.rd + 38'(t) * v.rd_stride;
      f    = 8'(t);
      exp_q.push_back({5'h08, f, 19'b0, v.acc});
      exp_q.push_back({5'h09, f, 31'b0, v.vl});
      exp_q.push_back({5'h0C, f, 13'b0, rs_t});
      exp_q.push_back({5'h0D, f, 13'b0, v.rt});
      exp_q.push_back({5'h0E, f, 13'b0, rd_t});
      exp_q.push_back({5'h0A, f, 50'b0, 1'b1});
    end
    for (int t = int'(v.nthr) + 1; t < NTHR; t++) begin
      f = 8'(t);
      exp_q.push_back({5'h0A, f, 51'b0});
    end
    exp_q.push_back({5'h01, 59'b0});
    if (v.act == 2'd1) exp_q.push_back({5'h02, 8'h00, 51'b0});
    if (v.act == 2'd2) exp_q.push_back({5'h02, 8'h01, 44'b0, v.lsh});
    exp_q.push_back({5'h10, 59'b0});
    exp_q.push_back({5'h18, 57'b0, v.sync});
  endtask

  task automatic driveDesc(input vec_t v);
    i_job_nthr = v.nthr;  i_job_acc = v.acc;  i_job_vl = v.vl;
    i_job_rs = v.rs;      i_job_rd = v.rd;
    i_job_rs_stride = v.rs_stride;  i_job_rd_stride = v.rd_stride;
    i_job_rt = v.rt;      i_job_act = v.act;  i_job_lsh = v.lsh;
    i_job_sync = v.sync;
  endtask

  // Runs one job: accept, scramble descriptor inputs, collect every word
  // (with optional random back-pressure), then compare the stream.
  task automatic applyStimulus(input vec_t v, input int idx);
    int          cycles = 0;
    int          drops = 0;
    bit          rdy;
    bit          stalled_prev = 0;
    logic [63:0] prev_word = '0;
    logic [63:0] probe;
    buildExpected(v);
    driveDesc(v);
    i_cmd_ready = 1'b1;
    i_job_valid = 1'b1;
    checkOutput($sformatf("v%0d job_ready_idle", idx), 64'(o_job_ready), 64'd1);
    @(posedge clk); #1;
    i_job_valid = 1'b0;
    i_job_nthr = ~v.nthr;  i_job_acc = ~v.acc;  i_job_vl = ~v.vl;
    i_job_rs = ~v.rs;  i_job_rd = ~v.rd;  i_job_rt = ~v.rt;
    i_job_rs_stride = ~v.rs_stride;  i_job_rd_stride = ~v.rd_stride;
    i_job_act = ~v.act;  i_job_lsh = ~v.lsh;  i_job_sync = ~v.sync;
    checkOutput($sformatf("v%0d first_valid", idx), 64'(o_cmd_valid), 64'd1);
    checkOutput($sformatf("v%0d busy", idx), 64'(o_busy), 64'd1);
    checkOutput($sformatf("v%0d job_ready_busy", idx), 64'(o_job_ready), 64'd0);
    got_q.delete();
    while (got_q.size() < v.exp_count && cycles < 1000) begin
      if (stalled_prev)
        checkOutput($sformatf("v%0d stall_hold", idx), o_cmd, prev_word);
      if (!o_cmd_valid) drops++;
      rdy = v.stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      i_cmd_ready = rdy;
      if (o_cmd_valid && rdy) got_q.push_back(o_cmd);
      stalled_prev = o_cmd_valid && !rdy;
      prev_word = o_cmd;
      @(posedge clk); #1;
      cycles++;
    end
    i_cmd_ready = 1'b1;
    checkOutput($sformatf("v%0d word_count", idx), 64'(got_q.size()), 64'(v.exp_count));
    checkOutput($sformatf("v%0d valid_drops", idx), 64'(drops), 64'd0);
    if (!v.stall)
      checkOutput($sformatf("v%0d cycles", idx), 64'(cycles), 64'(v.exp_count));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      checkOutput($sformatf("v%0d word[%0d]", idx, i), got_q[i], exp_q[i]);
    probe = (v.probe_idx0 < got_q.size()) ? got_q[v.probe_idx0] : 64'hx;
    checkOutput($sformatf("v%0d probe0", idx), probe, v.probe_word0);
    probe = (v.probe_idx1 < got_q.size()) ? got_q[v.probe_idx1] : 64'hx;
    checkOutput($sformatf("v%0d probe1", idx), probe, v.probe_word1);
    checkOutput($sformatf("v%0d end_valid", idx), 64'(o_cmd_valid), 64'd0);
    checkOutput($sformatf("v%0d end_busy", idx), 64'(o_busy), 64'd0);
    checkOutput($sformatf("v%0d end_job_ready", idx), 64'(o_job_ready), 64'd1);
  endtask

  initial begin
    // Single thread, no activation: 6 + 7 + 3 = 16 words.
    vecs[0] = '{nthr:3'd0, acc:32'hFFFF_FFFF, vl:20'd100, rs:38'h11, rd:38'h22,
                rs_stride:38'h4, rd_stride:38'h8, rt:38'h33, act:2'd0, lsh:7'd0,
                sync:2'd1, stall:0, exp_count:16,
                probe_idx0:0,  probe_word0:{5'h08, 8'h00, 19'b0, 32'hFFFF_FFFF},
                probe_idx1:12, probe_word1:{5'h0A, 8'h07, 51'b0}};
    // All threads, LRELU: 48 + 0 + 3 + 1 = 52 words.
    vecs[1] = '{nthr:3'd7, acc:32'h1234_5678, vl:20'h00400, rs:38'h1000, rd:38'h2000,
                rs_stride:38'd40, rd_stride:38'd8, rt:38'h3000, act:2'd2, lsh:7'h04,
                sync:2'd3, stall:0, exp_count:52,
                probe_idx0:44, probe_word0:{5'h0C, 8'h07, 13'b0, 38'h1118},
                probe_idx1:46, probe_word1:{5'h0E, 8'h07, 13'b0, 38'h2038}};
    // Four threads, reserved act, random stalls: 24 + 4 + 3 = 31 words.
    vecs[2] = '{nthr:3'd3, acc:32'hA5A5_0001, vl:20'hFFFFF, rs:38'h3F_0000_0000,
                rd:38'h100, rs_stride:38'h100, rd_stride:38'h3_0000, rt:38'h2A_AAAA_AAAA,
                act:2'd3, lsh:7'h7F, sync:2'd2, stall:1, exp_count:31,
                probe_idx0:28, probe_word0:{5'h01, 59'b0},
                probe_idx1:29, probe_word1:{5'h10, 59'b0}};
    // Same job without stalls must give the same stream.
    vecs[3] = vecs[2];
    vecs[3].stall = 0;
    // Address wrap on thread 1, RELU: 12 + 6 + 3 + 1 = 22 words.
    vecs[4] = '{nthr:3'd1, acc:32'h0, vl:20'd1, rs:38'h3F_FFFF_FFF0, rd:38'h5,
                rs_stride:38'h10, rd_stride:38'h1, rt:38'h0, act:2'd1, lsh:7'h09,
                sync:2'd0, stall:0, exp_count:22,
                probe_idx0:8,  probe_word0:{5'h0C, 8'h01, 13'b0, 38'h0},
                probe_idx1:19, probe_word1:{5'h02, 8'h00, 51'b0}};
    // All threads, no activation: 48 + 3 = 51 words, SYNC payload last.
    vecs[5] = '{nthr:3'd7, acc:32'h8000_0000, vl:20'h12345, rs:38'h0, rd:38'h3F_FFFF_FFFF,
                rs_stride:38'h1, rd_stride:38'h1, rt:38'h1, act:2'd0, lsh:7'h0,
                sync:2'd2, stall:0, exp_count:51,
                probe_idx0:50, probe_word0:{5'h18, 57'b0, 2'b10},
                probe_idx1:47, probe_word1:{5'h0A, 8'h07, 50'b0, 1'b1}};

    nrst = 1'b0;
    i_job_valid = 1'b0;
    i_cmd_ready = 1'b1;
    driveDesc(vecs[0]);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset valid", 64'(o_cmd_valid), 64'd0);
    checkOutput("reset busy", 64'(o_busy), 64'd0);
    checkOutput("reset cmd", o_cmd, 64'd0);
    nrst = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset job_ready", 64'(o_job_ready), 64'd1);

    for (int i = 0; i < 6; i++) begin
      $display("[TB] running vector %0d", i);
      applyStimulus(vecs[i], i);
      @(posedge clk); #1;
    end

    // Reset while thread 2 is being set up; the job must be abandoned.
    $display("[TB] reset during thread 2 setup");
    driveDesc(vecs[1]);
    i_job_valid = 1'b1;
    @(posedge clk); #1;
    i_job_valid = 1'b0;
    repeat (14) begin
      @(posedge clk); #1;
    end
    nrst = 1'b0;
    @(posedge clk); #1;
    checkOutput("midreset valid", 64'(o_cmd_valid), 64'd0);
    checkOutput("midreset busy", 64'(o_busy), 64'd0);
    checkOutput("midreset cmd", o_cmd, 64'd0);
    nrst = 1'b1;
    checkOutput("midreset job_ready", 64'(o_job_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("midreset quiet%0d", i), 64'(o_cmd_valid), 64'd0);
    end
    applyStimulus(vecs[4], 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
